// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults, the count type and the parameter legality
// helper used by the modulo-N counter.
// Optional feature macro: COUNTER_SATURATE_EN. When it is defined, the
// counter holds at its terminal value instead of wrapping.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEF = 7;
    localparam int COUNTER_MAX_DEF   = 99;

    typedef logic [COUNTER_WIDTH_DEF-1:0] count_t;

    // Legal when the terminal value is nonzero and fits in the count width.
    function automatic bit params_legal(input int width, input int max_val);
        return (max_val >= 1) && (width >= 1) && (width <= 31) && (max_val < (1 << width));
    endfunction

endpackage

// File: rtl/counter_next.sv
// counter_next: combinational next-state function of the modulo-N counter.
// It applies reset priority, recovery from out-of-range values, and then
// either a wrap or a hold at the terminal value.
// Optional feature macro: COUNTER_SATURATE_EN (hold at MAX instead of wrapping).
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEF,
    parameter int MAX   = COUNTER_MAX_DEF
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] count_next_o,
    output logic             terminal_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);

    // Next-count selection. Reset wins over everything, and any value at or
    // above MAX is handled by the terminal branch. Values above MAX, which can
    // only exist before the first reset, always go to zero.
    always_comb begin
        terminal_o   = (count_i == MaxVal);
        count_next_o = count_i + OneVal;
        if (rst_i) begin
            count_next_o = '0;
        end else if (count_i >= MaxVal) begin
`ifdef COUNTER_SATURATE_EN
            count_next_o = (count_i == MaxVal) ? MaxVal : '0;
`else
            count_next_o = '0;
`endif
        end
    end

endmodule

// File: rtl/counter.sv
// counter: free-running synchronous modulo-(MAX+1) up-counter. The output
// comes straight from a register, and reset is synchronous and active-high.
// Optional feature macro: COUNTER_SATURATE_EN (hold at MAX instead of wrapping).
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEF,
    parameter int MAX   = COUNTER_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             terminal_unused;

    // Reject configurations whose terminal value is zero or does not fit in WIDTH.
    generate
        if (!params_legal(WIDTH, MAX)) begin : gen_bad_params
            $error("counter: illegal parameters WIDTH=%0d MAX=%0d (need 1 <= MAX < 2**WIDTH)",
                   WIDTH, MAX);
        end
    endgenerate

    counter_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .count_i      (count_q),
        .rst_i        (rst),
        .count_next_o (count_d),
        .terminal_o   (terminal_unused)
    );

    // Count register. Reset is folded into count_d, so this register stays a plain flop.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed, table-driven bench for the modulo-N counter. It drives
// the default 7-bit/mod-100 instance and a WIDTH=4, MAX=9 instance side by side.
// Optional feature macro: COUNTER_SATURATE_EN (expectations switch to hold-at-MAX).
module tb_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    count_t     count;
    logic [3:0] countSmall;

    int checks = 0;
    int errors = 0;
    int modelCount = 0;
    int modelSmall = 0;

    typedef struct {
        bit rstIn;
        int expCount;
        int expSmall;
    } vec_t;

    vec_t vectors[12];

    // 10 MHz clock.
    always #50 clk = ~clk;

    counter dut (
        .clk   (clk),
        .rst   (rst),
        .count (count)
    );

    counter #(
        .WIDTH (4),
        .MAX   (9)
    ) dutSmall (
        .clk   (clk),
        .rst   (rst),
        .count (countSmall)
    );

    // Scoreboard next-state model.
    function automatic int nextModel(input int cur, input int maxV, input bit r);
        if (r) return 0;
        if (cur > maxV) return 0;
`ifdef COUNTER_SATURATE_EN
        if (cur == maxV) return maxV;
`else
        if (cur == maxV) return 0;
`endif
        return cur + 1;
    endfunction

    // Closed-form value after k counting edges that follow a reset.
    function automatic int expectedAfter(input int k, input int maxV);
`ifdef COUNTER_SATURATE_EN
        return (k > maxV) ? maxV : k;
`else
        return k % (maxV + 1);
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive rst, let one rising edge pass, sample 1 ns later and advance the models.
    task automatic applyStimulus(input bit r);
        rst = r;
        @(posedge clk);
        #1;
        modelCount = nextModel(modelCount, COUNTER_MAX_DEF, r);
        modelSmall = nextModel(modelSmall, 9, r);
    endtask

    initial begin
        // Power-up reset, first counts, then a short reset and a restart.
        vectors[0]  = '{1'b1, 0, 0};
        vectors[1]  = '{1'b0, 1, 1};
        vectors[2]  = '{1'b0, 2, 2};
        vectors[3]  = '{1'b0, 3, 3};
        vectors[4]  = '{1'b0, 4, 4};
        vectors[5]  = '{1'b1, 0, 0};
        vectors[6]  = '{1'b1, 0, 0};
        vectors[7]  = '{1'b0, 1, 1};
        vectors[8]  = '{1'b0, 2, 2};
        vectors[9]  = '{1'b0, 3, 3};
        vectors[10] = '{1'b1, 0, 0};
        vectors[11] = '{1'b0, 1, 1};

        #20;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vectors[i].rstIn);
            checkOutput($sformatf("vec%0d count", i), int'(count), vectors[i].expCount);
            checkOutput($sformatf("vec%0d countSmall", i), int'(countSmall), vectors[i].expSmall);
        end

        // Wrap: 120 edges after a reset.
        applyStimulus(1'b1);
        checkOutput("wrap reset", int'(count), 0);
        for (int k = 1; k <= 120; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("wrap edge%0d", k), int'(count), modelCount);
            checkOutput($sformatf("wrap small edge%0d", k), int'(countSmall), modelSmall);
            if (countSmall > 4'd9) begin
                checkOutput("small range", int'(countSmall), 9);
            end
            if (k == 98 || k == 99 || k == 100 || k == 101 || k == 120) begin
                checkOutput($sformatf("wrap const%0d", k), int'(count),
                            expectedAfter(k, COUNTER_MAX_DEF));
                checkOutput($sformatf("wrap small const%0d", k), int'(countSmall),
                            expectedAfter(k, 9));
            end
        end

        // Mid-count reset held for 10 cycles.
        applyStimulus(1'b1);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0);
        checkOutput("mid pre", int'(count), 20);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("mid held%0d", k), int'(count), 0);
            checkOutput($sformatf("mid small held%0d", k), int'(countSmall), 0);
        end
        applyStimulus(1'b0);
        checkOutput("mid release", int'(count), 1);
        for (int k = 0; k < 119; k++) applyStimulus(1'b0);
        checkOutput("mid after120", int'(count), expectedAfter(120, COUNTER_MAX_DEF));
        checkOutput("mid small after120", int'(countSmall), expectedAfter(120, 9));

        // Reset arriving exactly at the terminal value.
        applyStimulus(1'b1);
        for (int k = 0; k < 99; k++) applyStimulus(1'b0);
        checkOutput("term at99", int'(count), 99);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("term held%0d", k), int'(count), 0);
        end

        // Small instance: reset exactly at 9.
        for (int k = 0; k < 9; k++) applyStimulus(1'b0);
        checkOutput("small at9", int'(countSmall), 9);
        applyStimulus(1'b1);
        checkOutput("small term reset", int'(countSmall), 0);

        // Continuous run: 1000 edges after reset.
        applyStimulus(1'b1);
        checkOutput("run reset", int'(count), 0);
        for (int k = 1; k <= 1000; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("run edge%0d", k), int'(count),
                        expectedAfter(k, COUNTER_MAX_DEF));
            checkOutput($sformatf("run model edge%0d", k), int'(count), modelCount);
            checkOutput($sformatf("run small edge%0d", k), int'(countSmall),
                        expectedAfter(k, 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Free-running synchronous modulo-N up-counter with a 7-bit binary output.
- Advances once per rising clock edge and wraps to zero after reaching its terminal value.
- Leaf block used as a timebase or sequence index by surrounding logic; no enable or load inputs.
- Default terminal value 99 gives a 0–99 (mod-100) sequence.

Parameters:
- WIDTH, 7, bit width of count; must satisfy 2**WIDTH > MAX.
- MAX, 99, terminal count value; legal range 1 .. 2**WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- count  output  WIDTH (7)  current count value, driven directly from a register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: if rst=1 at a rising edge of clk, count <= 0 at that edge.
  - No asynchronous effect; count holds its previous value between edges even while rst=1.
  - Held reset keeps count at 0 for every cycle rst remains 1.
- Count: if rst=0 at a rising edge:
  - count < MAX: count <= count+1.
  - count == MAX: count <= 0 (wrap).
- Latency: count reflects the increment one edge after sampling; the first edge with rst=0 after reset produces count=1.
- Reset priority: rst overrides wrap and increment when they coincide, including at count==MAX.
- Reset mid-count: any value returns to 0 on the next edge; counting resumes from 0 after rst falls.
- Out-of-range state: if count > MAX, next edge gives 0 (only possible before first reset). Treat the power-up value as X until the first reset edge.
- Arithmetic: unsigned, WIDTH bits. The increment never overflows because MAX < 2**WIDTH. Compare with ">= MAX" for robustness.
- Output: purely registered, no combinational path from inputs to count.
- Elaboration check: fail elaboration (assertion or $error) if MAX >= 2**WIDTH or MAX == 0.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: on reaching MAX, count holds at MAX instead of wrapping. Only rst returns it to 0. The out-of-range rule (count > MAX -> 0) still applies.
- Undefined (default): wrap-around mod (MAX+1) as described above.

Decomposition:
- Package counter_pkg:
  - localparams COUNTER_WIDTH_DEF=7 and COUNTER_MAX_DEF=99.
  - typedef count_t (logic [COUNTER_WIDTH_DEF-1:0]).
- Sub-module counter_next: combinational next-state function.
  - Inputs: count, rst.
  - Outputs: next count and a terminal flag.
  - Top level holds only the register and the parameter checks.

Test Plan (10 MHz clock, period 100 ns):
- Power-up reset: rst=1 for 1 cycle -> count=0 at that edge; rst=0 -> count=1,2,3 on the following edges.
- Wrap: after reset, 120 edges with rst=0 -> count passes 98, 99, 0, 1 … and reads 20 after the 120th edge. With COUNTER_SATURATE_EN it reads 99 from the 99th edge onward.
- Mid-count reset: at count=20, hold rst=1 for 10 cycles -> count=0 on the first reset edge and stays 0 for all 10. After release, count=1 on the next edge; after 120 more edges, count=20.
- Reset at terminal: assert rst exactly when count=99 -> next value 0 (not a wrap artifact), and count stays 0 while held.
- Parameter variant: WIDTH=4, MAX=9 -> sequence 0..9,0; count never exceeds 9. Illegal WIDTH=3, MAX=9 -> elaboration error.
- Continuous run: 1000 edges after reset -> count == (edges mod 100) at every edge; the checker compares against a scoreboard model.
